alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised successor to the single-cycle ALU decode path: decodes ALUOp/funct into an extended 4-bit control, executes single-cycle ALU ops combinationally, and adds an iterative multiply/divide unit with HI/LO registers. Sits in the execute stage between the main control unit and the register-file write-back mux. The iterative unit stalls only HI/LO-dependent instructions.

## Interface
- WIDTH, 32, datapath width; must be a power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  instruction present this cycle
- ALUOp  in  2  from main control
- funct  in  6  instruction funct field
- shamt  in  SHW  shift amount
- srcA  in  WIDTH  operand A (rs)
- srcB  in  WIDTH  operand B (rt or immediate)
- result  out  WIDTH  ALU/move result, combinational
- zero  out  1  result == 0
- result_valid  out  1  valid_in & ~stall & ~illegal
- stall  out  1  instruction cannot issue this cycle
- illegal  out  1  valid_in with unrecognised encoding
- busy  out  1  multiply/divide in progress

## Operation
- ALUOp 00 → add; 01 → sub; 11 → signed slt; 10 → funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt signed, 101011 sltu
  - 000000 sll, 000010 srl, 000011 sra (by shamt)
  - 011000 mult, 011001 multu, 011010 div, 011011 divu (start MDU; result = 0)
  - 010000 mfhi, 010010 mflo (result = HI/LO)
  - any other funct: illegal=1, result=0; no state change. No latched outputs; every path assigns.
- Add/sub wrap modulo 2^WIDTH; no overflow flag. slt/sltu result is zero-extended 1 bit.
- stall = valid_in & busy & (op is mult/div/mfhi/mflo). Non-MDU ops issue during busy.
- MDU FSM: IDLE → MUL or DIV on accepted start → FIX after WIDTH iterations → IDLE.
  - Operands latched on accept; signed ops use magnitudes; FIX applies sign correction and writes HI/LO.
  - MUL: shift-add, 1 bit/cycle; {HI,LO} = 2·WIDTH-bit product.
  - DIV: restoring, 1 bit/cycle; LO = quotient, HI = remainder (sign of dividend).
  - Divide by zero: LO = all ones, HI = dividend; still full latency.
- Reset: FSM → IDLE, HI = LO = 0, busy = 0, counter = 0. Reset mid-operation aborts; HI/LO cleared, no partial write.

## Timing
- Single-cycle ops: result same cycle as inputs; no registers on path.
- Start accepted on edge E0; busy = 1 for cycles E0+1 … E0+WIDTH+1 (WIDTH iterations + FIX).
- HI/LO updated on the edge ending FIX; busy drops the same edge.
- mfhi/mflo in first non-busy cycle returns the new value (WIDTH=32: mult on edge 0 → mfhi issues cycle 34).
- Start or mfhi/mflo while busy: stalled, not accepted, no effect; upstream holds inputs.
- Reset has priority over any accept in the same cycle.
- Reset values: busy 0, stall 0, result_valid 0, illegal 0 (outputs gated by reset).

## Configuration
- ALU_DIV_EN defined: div/divu decoded, DIV state and divider datapath present.
- Undefined: funct 011010/011011 → illegal=1, no MDU start; FSM has only IDLE/MUL/FIX; divider logic absent.

## Structure
- Package alu_pkg: ALUOp encodings, funct constants, 4-bit ALU control enum, MDU state enum.
- Sub-module mdu_seq: FSM, iteration counter, operand/accumulator registers, HI/LO; exposes start, op, busy, hi, lo.
- alu_exec_unit: decoder, combinational ALU, stall logic, mdu_seq instance.

## Test plan
- ALUOp=10, funct=101010, srcA=0xFFFFFFFF, srcB=1 → result=1; funct=101011 → result=0.
- funct=000011, shamt=4, srcB=0x80000000 → result=0xF8000000; funct=111111 → illegal=1, result=0.
- mult srcA=0xFFFFFFFE(−2), srcB=3 → busy 33 cycles; mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA; mfhi issued at cycle 5 → stall=1.
- div srcA=−7, srcB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu by 0 → LO=0xFFFFFFFF, HI=srcA (ALU_DIV_EN set); with macro unset → illegal=1.
- add issued during busy → result_valid=1, correct sum, MDU unaffected.
- reset asserted cycle 10 of multu → busy=0 next cycle, mfhi=mflo=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for alu_exec_unit: ALUOp, funct fields, ALU control and MDU state.
// ALU_DIV_EN adds the DIV state to the MDU state enum.
package alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_e;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_XOR, CTL_NOR,
        CTL_SLT, CTL_SLTU, CTL_SLL, CTL_SRL, CTL_SRA,
        CTL_MDU, CTL_MFHI, CTL_MFLO, CTL_NONE
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
    } mdu_op_e;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FIX} mdu_state_e;
`endif

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers, one bit per cycle.
// ALU_DIV_EN enables the restoring divider and the DIV state.
module mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef ALU_DIV_EN
    logic               neg_hi_q, neg_hi_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   fix_q, fix_r;
`endif

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        sgn   = (op == MDU_MULT) || (op == MDU_DIV);
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;

        // Shift-add: add multiplicand into the upper half when LSB set, then shift right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        prod    = neg_lo_q ? -acc_q : acc_q;

`ifdef ALU_DIV_EN
        neg_hi_d  = neg_hi_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
        fix_q     = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_r     = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
`ifdef ALU_DIV_EN
                    if ((op == MDU_DIV) || (op == MDU_DIVU)) begin
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        mcand_d  = mag_b;
                        neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = sgn && a[WIDTH-1];
                        div0_d   = (b == '0);
                        is_div_d = 1'b1;
                        state_d  = ST_DIV;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, mag_b};
                        mcand_d  = mag_a;
                        neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        is_div_d = 1'b0;
                        state_d  = ST_MUL;
                    end
`else
                    acc_d    = {{WIDTH{1'b0}}, mag_b};
                    mcand_d  = mag_a;
                    neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = ST_MUL;
`endif
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) state_d = ST_FIX;
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) state_d = ST_FIX;
            end
`endif
            ST_FIX: begin
`ifdef ALU_DIV_EN
                if (is_div_q) begin
                    lo_d = div0_q ? '1 : fix_q;
                    hi_d = fix_r;
                end else begin
                    {hi_d, lo_d} = prod;
                end
`else
                {hi_d, lo_d} = prod;
`endif
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef ALU_DIV_EN
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef ALU_DIV_EN
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALUOp/funct decode, single-cycle ALU, HI/LO stall logic, MDU.
// ALU_DIV_EN enables div/divu decode and the divider inside mdu_seq.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             result_valid,
    output logic             stall,
    output logic             illegal,
    output logic             busy
);

    alu_ctrl_e        ctrl;
    mdu_op_e          mdu_op;
    logic             ill_dec;
    logic             is_hilo;
    logic             mdu_busy;
    logic             mdu_start;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        ctrl    = CTL_NONE;
        mdu_op  = MDU_MULT;
        ill_dec = 1'b0;
        case (aluop_e'(ALUOp))
            ALUOP_ADD: ctrl = CTL_ADD;
            ALUOP_SUB: ctrl = CTL_SUB;
            ALUOP_SLT: ctrl = CTL_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   ctrl = CTL_ADD;
                    F_SUB:   ctrl = CTL_SUB;
                    F_AND:   ctrl = CTL_AND;
                    F_OR:    ctrl = CTL_OR;
                    F_XOR:   ctrl = CTL_XOR;
                    F_NOR:   ctrl = CTL_NOR;
                    F_SLT:   ctrl = CTL_SLT;
                    F_SLTU:  ctrl = CTL_SLTU;
                    F_SLL:   ctrl = CTL_SLL;
                    F_SRL:   ctrl = CTL_SRL;
                    F_SRA:   ctrl = CTL_SRA;
                    F_MFHI:  ctrl = CTL_MFHI;
                    F_MFLO:  ctrl = CTL_MFLO;
                    F_MULT:  begin ctrl = CTL_MDU; mdu_op = MDU_MULT;  end
                    F_MULTU: begin ctrl = CTL_MDU; mdu_op = MDU_MULTU; end
`ifdef ALU_DIV_EN
                    F_DIV:   begin ctrl = CTL_MDU; mdu_op = MDU_DIV;   end
                    F_DIVU:  begin ctrl = CTL_MDU; mdu_op = MDU_DIVU;  end
`endif
                    default: ill_dec = 1'b1;
                endcase
            end
            default: ill_dec = 1'b1;
        endcase
    end

    assign is_hilo = (ctrl == CTL_MDU) || (ctrl == CTL_MFHI) || (ctrl == CTL_MFLO);

    always_comb begin
        alu_res = '0;
        case (ctrl)
            CTL_ADD:  alu_res = srcA + srcB;
            CTL_SUB:  alu_res = srcA - srcB;
            CTL_AND:  alu_res = srcA & srcB;
            CTL_OR:   alu_res = srcA | srcB;
            CTL_XOR:  alu_res = srcA ^ srcB;
            CTL_NOR:  alu_res = ~(srcA | srcB);
            CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            CTL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            CTL_SLL:  alu_res = srcB << shamt;
            CTL_SRL:  alu_res = srcB >> shamt;
            CTL_SRA:  alu_res = $signed(srcB) >>> shamt;
            CTL_MFHI: alu_res = mdu_hi;
            CTL_MFLO: alu_res = mdu_lo;
            default:  alu_res = '0;
        endcase
    end

    // Non-HI/LO instructions keep issuing while the MDU iterates.
    assign mdu_start    = valid_in & ~reset & ~mdu_busy & (ctrl == CTL_MDU);
    assign busy         = mdu_busy & ~reset;
    assign stall        = valid_in & busy & is_hilo;
    assign illegal      = valid_in & ill_dec & ~reset;
    assign result_valid = valid_in & ~stall & ~illegal & ~reset;
    assign result       = alu_res;
    assign zero         = (alu_res == '0);

    mdu_seq #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk  (clk),
        .reset(reset),
        .start(mdu_start),
        .op   (mdu_op),
        .a    (srcA),
        .b    (srcB),
        .busy (mdu_busy),
        .hi   (mdu_hi),
        .lo   (mdu_lo)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=32); div checks depend on ALU_DIV_EN.
module tb_alu_exec_unit;

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    logic        clk = 1'b0;
    logic        reset, valid_in;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] srcA, srcB, result;
    logic        zero, result_valid, stall, illegal, busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] res_q[$];
    hilo_t       sb_q[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
        .shamt(shamt), .srcA(srcA), .srcB(srcB), .result(result), .zero(zero),
        .result_valid(result_valid), .stall(stall), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic hilo_t mdu_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        hilo_t r;
        longint p;
        logic [63:0] pu;
        r = '0;
        case (f)
            6'b011000: begin p = longint'($signed(a)) * longint'($signed(b)); r.hi = p[63:32]; r.lo = p[31:0]; end
            6'b011001: begin pu = {32'd0, a} * {32'd0, b}; r.hi = pu[63:32]; r.lo = pu[31:0]; end
            6'b011010: begin
                if (b == 32'd0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
                else begin
                    p = longint'($signed(a)) / longint'($signed(b)); r.lo = p[31:0];
                    p = longint'($signed(a)) % longint'($signed(b)); r.hi = p[31:0];
                end
            end
            6'b011011: begin
                if (b == 32'd0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
        ALUOp = op; funct = f; shamt = sh; srcA = a; srcB = b; valid_in = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        set_in(op, f, sh, a, b);
    endtask

    task automatic read_now(output logic [31:0] hi, output logic [31:0] lo, output logic rvh, output logic rvl);
        set_in(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        hi = result; rvh = result_valid;
        drive(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);
        lo = result; rvl = result_valid;
    endtask

    // Counts busy cycles after an accepted start; optionally issues two instructions mid-run.
    task automatic wait_busy(input int p1_at, input vec_t p1, input int p2_at, input vec_t p2,
                             output int n, output bit to,
                             output logic s1, output logic r1, output logic [31:0] x1,
                             output logic s2, output logic r2);
        n = 0; to = 1'b1; s1 = 1'b0; r1 = 1'b0; x1 = '0; s2 = 1'b0; r2 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) begin to = 1'b0; break; end
            n++;
            if (n == p1_at) begin
                set_in(p1.op, p1.f, p1.sh, p1.a, p1.b); s1 = stall; r1 = result_valid; x1 = result;
            end else if (n == p2_at) begin
                set_in(p2.op, p2.f, p2.sh, p2.a, p2.b); s2 = stall; r2 = result_valid;
            end else begin
                valid_in = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        logic rvh, rvl;
        hilo_t e;
        reset = 1'b1;
        drive(2'b10, 6'b011000, 5'd0, 32'd5, 32'd7);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", result_valid); end
        drive(2'b10, 6'b111111, 5'd0, 32'd0, 32'd0);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
        sb_q.push_back('0);
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_accept: got %b want 0", busy); end
        read_now(hi, lo, rvh, rvl);
        e = sb_q.pop_front();
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL rst_hi: got %h want %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL rst_lo: got %h want %h", lo, e.lo); end
    endtask

    task automatic test_alu();
        vec_t v[16];
        logic [31:0] e;
        v[0]  = '{2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0};
        v[1]  = '{2'b10, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
        v[2]  = '{2'b10, 6'b000011, 5'd4, 32'd0, 32'h80000000, 32'hF8000000, 1'b0};
        v[3]  = '{2'b10, 6'b111111, 5'd0, 32'h1234, 32'h4321, 32'd0, 1'b1};
        v[4]  = '{2'b00, 6'b000000, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0};
        v[5]  = '{2'b01, 6'b000000, 5'd0, 32'd5, 32'd5, 32'd0, 1'b0};
        v[6]  = '{2'b11, 6'b000000, 5'd0, 32'd3, 32'hFFFFFFFF, 32'd0, 1'b0};
        v[7]  = '{2'b10, 6'b100100, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        v[8]  = '{2'b10, 6'b100101, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        v[9]  = '{2'b10, 6'b100110, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        v[10] = '{2'b10, 6'b100111, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 1'b0};
        v[11] = '{2'b10, 6'b000000, 5'd8, 32'd0, 32'h12345678, 32'h34567800, 1'b0};
        v[12] = '{2'b10, 6'b000010, 5'd4, 32'd0, 32'h80000000, 32'h08000000, 1'b0};
        v[13] = '{2'b10, 6'b100000, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0};
        v[14] = '{2'b10, 6'b000001, 5'd0, 32'd9, 32'd9, 32'd0, 1'b1};
        v[15] = '{2'b10, 6'b100010, 5'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0};
        for (int i = 0; i < 16; i++) begin
            res_q.push_back(v[i].exp);
            drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b);
            e = res_q.pop_front();
            checks++; if (result !== e) begin errors++; $display("FAIL alu_res[%0d]: got %h want %h", i, result, e); end
            checks++; if (illegal !== v[i].ill) begin errors++; $display("FAIL alu_ill[%0d]: got %b want %b", i, illegal, v[i].ill); end
            checks++; if (result_valid !== !v[i].ill) begin errors++; $display("FAIL alu_rv[%0d]: got %b want %b", i, result_valid, !v[i].ill); end
            checks++; if (zero !== (e == 32'd0)) begin errors++; $display("FAIL alu_zero[%0d]: got %b want %b", i, zero, (e == 32'd0)); end
        end
    endtask

    task automatic test_mult();
        vec_t p1, p2;
        int n; bit to;
        logic s1, r1, s2, r2, rvh, rvl;
        logic [31:0] x1, hi, lo;
        hilo_t e;
        p1 = '{2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        p2 = '{2'b10, 6'b011000, 5'd0, 32'd5, 32'd5, 32'd0, 1'b0};
        sb_q.push_back(mdu_model(6'b011000, 32'hFFFFFFFE, 32'd3));
        drive(2'b10, 6'b011000, 5'd0, 32'hFFFFFFFE, 32'd3);
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL mult_start_res: got %h want 0", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL mult_start_rv: got %b want 1", result_valid); end
        wait_busy(5, p1, 7, p2, n, to, s1, r1, x1, s2, r2);
        checks++; if (to) begin errors++; $display("FAIL mult_timeout: got busy after %0d cycles want idle", n); end
        checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_len: got %0d want 33", n); end
        checks++; if (s1 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL mfhi_stall: got stall=%b rv=%b want 1/0", s1, r1); end
        checks++; if (s2 !== 1'b1 || r2 !== 1'b0) begin errors++; $display("FAIL mult_restart_stall: got stall=%b rv=%b want 1/0", s2, r2); end
        read_now(hi, lo, rvh, rvl);
        e = sb_q.pop_front();
        checks++; if (rvh !== 1'b1) begin errors++; $display("FAIL mult_mfhi_rv: got %b want 1", rvh); end
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL mult_hi: got %h want %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL mult_lo: got %h want %h", lo, e.lo); end
    endtask

    task automatic test_busy_add();
        vec_t p1, p2;
        int n; bit to;
        logic s1, r1, s2, r2, rvh, rvl;
        logic [31:0] x1, hi, lo;
        hilo_t e;
        p1 = '{2'b10, 6'b100000, 5'd0, 32'h1234, 32'h4321, 32'd0, 1'b0};
        p2 = '0;
        sb_q.push_back(mdu_model(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF));
        drive(2'b10, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_busy(3, p1, -1, p2, n, to, s1, r1, x1, s2, r2);
        checks++; if (to || n !== 33) begin errors++; $display("FAIL multu_busy_len: got %0d (to=%b) want 33", n, to); end
        checks++; if (s1 !== 1'b0 || r1 !== 1'b1) begin errors++; $display("FAIL add_busy_issue: got stall=%b rv=%b want 0/1", s1, r1); end
        checks++; if (x1 !== 32'h5555) begin errors++; $display("FAIL add_busy_res: got %h want 00005555", x1); end
        read_now(hi, lo, rvh, rvl);
        e = sb_q.pop_front();
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL multu_hi: got %h want %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL multu_lo: got %h want %h", lo, e.lo); end
    endtask

    task automatic test_div();
        logic [5:0]  df[2];
        logic [31:0] da[2], db[2];
`ifdef ALU_DIV_EN
        vec_t p;
        int n; bit to;
        logic s1, r1, s2, r2, rvh, rvl;
        logic [31:0] x1, hi, lo;
        hilo_t e;
        p = '0;
`endif
        df[0] = 6'b011010; da[0] = 32'hFFFFFFF9; db[0] = 32'd2;
        df[1] = 6'b011011; da[1] = 32'h12345678; db[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
`ifdef ALU_DIV_EN
            sb_q.push_back(mdu_model(df[i], da[i], db[i]));
            drive(2'b10, df[i], 5'd0, da[i], db[i]);
            checks++; if (result_valid !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL div_start[%0d]: got rv=%b ill=%b want 1/0", i, result_valid, illegal); end
            wait_busy(-1, p, -1, p, n, to, s1, r1, x1, s2, r2);
            checks++; if (to || n !== 33) begin errors++; $display("FAIL div_busy_len[%0d]: got %0d want 33", i, n); end
            read_now(hi, lo, rvh, rvl);
            e = sb_q.pop_front();
            checks++; if (hi !== e.hi) begin errors++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, e.hi); end
            checks++; if (lo !== e.lo) begin errors++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, e.lo); end
`else
            drive(2'b10, df[i], 5'd0, da[i], db[i]);
            checks++; if (illegal !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL div_illegal[%0d]: got ill=%b rv=%b want 1/0", i, illegal, result_valid); end
            checks++; if (result !== 32'd0) begin errors++; $display("FAIL div_res[%0d]: got %h want 0", i, result); end
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_no_start[%0d]: got busy=%b want 0", i, busy); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo;
        logic rvh, rvl;
        hilo_t e;
        sb_q.push_back(mdu_model(6'b011001, 32'd7, 32'd9));
        drive(2'b10, 6'b011001, 5'd0, 32'd7, 32'd9);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1'b1;
        sb_q.delete();
        sb_q.push_back('0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_abort: got busy=%b want 0", busy); end
        read_now(hi, lo, rvh, rvl);
        e = sb_q.pop_front();
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL mid_hi: got %h want %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL mid_lo: got %h want %h", lo, e.lo); end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ALUOp = '0; funct = '0; shamt = '0; srcA = '0; srcB = '0;
        test_reset();
        test_alu();
        test_mult();
        test_busy_add();
        test_div();
        test_reset_mid();
        @(negedge clk);
        valid_in = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
